// File: rtl/kt_pkg.sv
// Shared types and constants for the kt3 operand issuer.
package kt_pkg;

    localparam int KT_DATA_W = 64;

    localparam logic [63:0] FP64_ZERO = 64'h0000000000000000;
    localparam logic [63:0] FP64_ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] FP64_TWO  = 64'h4000000000000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } kt_iss_state_e;

endpackage

// File: rtl/kt_operand_issuer_if.sv
// Operand RAM read port plus valid-only operand stream into the kt3 datapath.
interface kt_operand_issuer_if
    import kt_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = KT_DATA_W
) ();
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_psi_pow4;
    logic [DATA_W-1:0] mem_r_i;
    logic [DATA_W-1:0] mem_alpha_r;
    logic [DATA_W-1:0] psi_pow4;
    logic [DATA_W-1:0] r_i;
    logic [DATA_W-1:0] alpha_r;
    logic              psipow4_vld;
    logic              alpha_r_vld;
    logic              kt3_result_vld;

    modport master (
        output mem_rd_en, mem_rd_addr,
        input  mem_psi_pow4, mem_r_i, mem_alpha_r,
        output psi_pow4, r_i, alpha_r, psipow4_vld, alpha_r_vld,
        input  kt3_result_vld
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr,
        output mem_psi_pow4, mem_r_i, mem_alpha_r,
        input  psi_pow4, r_i, alpha_r, psipow4_vld, alpha_r_vld,
        output kt3_result_vld
    );
endinterface

// File: rtl/kt_vld_delay.sv
// DEPTH-stage shift register of {vld, data}; synchronous clear so nothing stale survives rst.
module kt_vld_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);
    logic [DEPTH-1:0]            r_vld_pipe;
    logic [DEPTH-1:0][WIDTH-1:0] r_data_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe  <= '0;
            r_data_pipe <= '0;
        end else begin
            r_vld_pipe[0]  <= i_vld;
            r_data_pipe[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_data_pipe[i] <= r_data_pipe[i-1];
            end
        end
    end

    assign o_vld  = r_vld_pipe[DEPTH-1];
    assign o_data = r_data_pipe[DEPTH-1];
endmodule

// File: rtl/kt_operand_issuer.sv
// Credit-metered operand issuer for the kt3 datapath.
// Optional KT_ALPHA_SKEW_EN adds an ALPHA_SKEW-cycle delay on the alpha_r stream.
module kt_operand_issuer
    import kt_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = KT_DATA_W,
    parameter int RD_LAT       = 2,
    parameter int MAX_INFLIGHT = 32,
    parameter int ALPHA_SKEW   = 20,
    localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   n_points,
    output logic                busy,
    output logic                done,
    output logic                err_unexpected,
    output logic [CNT_W-1:0]    inflight,
    kt_operand_issuer_if.master bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    kt_iss_state_e     r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, r_n;
    logic [CNT_W-1:0]  r_inflight, w_inflight_nxt;
    logic              r_err;
    logic              w_issue;
    logic              w_rd_vld;
    logic [0:0]        w_rd_pipe_unused;
    logic              r_pvld;
    logic [DATA_W-1:0] r_psi, r_ri, r_alpha;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE:  if (start) w_state_nxt = (n_points != '0) ? ISSUE : DONE;
            ISSUE: begin
                w_issue = (r_addr < r_n) && (r_inflight < MAX_CNT);
                if (w_issue && (r_addr + ADDR_W'(1) == r_n)) w_state_nxt = DRAIN;
            end
            DRAIN: if ((r_inflight == '0) && !bus.kt3_result_vld) w_state_nxt = DONE;
            DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A return with nothing outstanding is flagged and never drives the count below zero.
    always_comb begin
        w_inflight_nxt = r_inflight;
        case ({w_issue, bus.kt3_result_vld})
            2'b10: w_inflight_nxt = r_inflight + CNT_W'(1);
            2'b01: if (r_inflight != '0) w_inflight_nxt = r_inflight - CNT_W'(1);
            2'b11: if (r_inflight == '0) w_inflight_nxt = CNT_W'(1);
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_n        <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_inflight_nxt;
            if ((r_state == IDLE) && start) begin
                r_n    <= n_points;
                r_addr <= '0;
            end else if (w_issue) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (bus.kt3_result_vld && (r_inflight == '0)) r_err <= 1'b1;
        end
    end

    kt_vld_delay #(.DEPTH(RD_LAT), .WIDTH(1)) u_rd_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_issue),
        .i_data (1'b0),
        .o_vld  (w_rd_vld),
        .o_data (w_rd_pipe_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pvld  <= 1'b0;
            r_psi   <= '0;
            r_ri    <= '0;
            r_alpha <= '0;
        end else begin
            r_pvld <= w_rd_vld;
            if (w_rd_vld) begin
                r_psi   <= bus.mem_psi_pow4;
                r_ri    <= bus.mem_r_i;
                r_alpha <= bus.mem_alpha_r;
            end
        end
    end

    assign bus.mem_rd_en   = w_issue;
    assign bus.mem_rd_addr = r_addr;
    assign bus.psi_pow4    = r_psi;
    assign bus.r_i         = r_ri;
    assign bus.psipow4_vld = r_pvld;

`ifdef KT_ALPHA_SKEW_EN
    // Alpha path lags so it meets the longer psi*r product downstream.
    kt_vld_delay #(.DEPTH(ALPHA_SKEW), .WIDTH(DATA_W)) u_alpha_skew (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (r_pvld),
        .i_data (r_alpha),
        .o_vld  (bus.alpha_r_vld),
        .o_data (bus.alpha_r)
    );
`else
    localparam int skew_unused = ALPHA_SKEW;
    assign bus.alpha_r_vld = r_pvld;
    assign bus.alpha_r     = r_alpha;
`endif

    assign busy           = (r_state != IDLE);
    assign done           = (r_state == DONE);
    assign err_unexpected = r_err;
    assign inflight       = r_inflight;
endmodule

// File: tb/tb_kt_operand_issuer.sv
// Directed bench for kt_operand_issuer: default instance plus a MAX_INFLIGHT=2 instance.
module tb_kt_operand_issuer;
    import kt_pkg::*;

    localparam int AW   = 10;
    localparam int DW   = 64;
    localparam int RDL  = 2;
    localparam int MAXI = 32;
    localparam int SKEW = 20;
    localparam int CW1  = $clog2(MAXI + 1);
    localparam int CW2  = $clog2(2 + 1);
`ifdef KT_ALPHA_SKEW_EN
    localparam int SK_EXP = SKEW;
`else
    localparam int SK_EXP = 0;
`endif
    localparam logic [63:0] PSI_B = 64'hA000_0000_0000_0000;
    localparam logic [63:0] RI_B  = 64'hB000_0000_0000_0000;
    localparam logic [63:0] AL_B  = 64'hC000_0000_0000_0000;

    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, start2 = 1'b0;
    logic [AW-1:0] n_points = '0, n_points2 = '0;
    logic busy, done, err, busy2, done2, err2;
    logic [CW1-1:0] inflight;
    logic [CW2-1:0] inflight2;
    logic auto_ret = 1'b0, man_ret = 1'b0, ret2 = 1'b0;

    kt_operand_issuer_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    kt_operand_issuer_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

    always #5 clk = ~clk;

    kt_operand_issuer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL), .MAX_INFLIGHT(MAXI),
                        .ALPHA_SKEW(SKEW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .n_points(n_points), .busy(busy),
        .done(done), .err_unexpected(err), .inflight(inflight), .bus(bus1));

    kt_operand_issuer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL), .MAX_INFLIGHT(2),
                        .ALPHA_SKEW(SKEW)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .n_points(n_points2), .busy(busy2),
        .done(done2), .err_unexpected(err2), .inflight(inflight2), .bus(bus2));

    // operand RAM model: addr-coded data, RDL=2 cycles after the read strobe
    logic [AW-1:0] ram_a1 = '0, ram_a2 = '0;
    always @(posedge clk) begin
        ram_a1 <= bus1.mem_rd_addr;
        ram_a2 <= ram_a1;
    end
    assign bus1.mem_psi_pow4   = PSI_B | 64'(ram_a2);
    assign bus1.mem_r_i        = RI_B  | 64'(ram_a2);
    assign bus1.mem_alpha_r    = AL_B  | 64'(ram_a2);
    assign bus1.kt3_result_vld = auto_ret | man_ret;
    assign bus2.mem_psi_pow4   = '0;
    assign bus2.mem_r_i        = '0;
    assign bus2.mem_alpha_r    = '0;
    assign bus2.kt3_result_vld = ret2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rd_cnt = 0, pv_cnt = 0, av_cnt = 0, done_cnt = 0, done_cyc = 0, max_inf = 0;
    int rd2_cnt = 0, done2_cnt = 0;
    int rd_cyc[32], rd_adr[32], pv_cyc[32], av_cyc[32];
    logic [63:0] pv_psi[32], pv_ri[32], av_dat[32];
    int ret_q[$];

    // event logger; also returns each point 30 cycles after its psipow4_vld
    always @(negedge clk) begin
        if (bus1.mem_rd_en) begin
            if (rd_cnt < 32) begin
                rd_cyc[rd_cnt] <= cyc;
                rd_adr[rd_cnt] <= int'(bus1.mem_rd_addr);
            end
            rd_cnt <= rd_cnt + 1;
        end
        if (bus1.psipow4_vld) begin
            if (pv_cnt < 32) begin
                pv_cyc[pv_cnt] <= cyc;
                pv_psi[pv_cnt] <= bus1.psi_pow4;
                pv_ri[pv_cnt]  <= bus1.r_i;
            end
            pv_cnt <= pv_cnt + 1;
            if (!rst) ret_q.push_back(cyc + 30);
        end
        if (bus1.alpha_r_vld) begin
            if (av_cnt < 32) begin
                av_cyc[av_cnt] <= cyc;
                av_dat[av_cnt] <= bus1.alpha_r;
            end
            av_cnt <= av_cnt + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (int'(inflight) > max_inf) max_inf <= int'(inflight);
        if (bus2.mem_rd_en) rd2_cnt <= rd2_cnt + 1;
        if (done2) done2_cnt <= done2_cnt + 1;
        if (rst) begin
            ret_q.delete();
            auto_ret <= 1'b0;
        end else if (ret_q.size() > 0 && ret_q[0] == cyc) begin
            auto_ret <= 1'b1;
            void'(ret_q.pop_front());
        end else begin
            auto_ret <= 1'b0;
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, rb, pb, ab, db, lim, last_ret;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_rd_en", bus1.mem_rd_en, 0);
        chk("rst_rd_addr", bus1.mem_rd_addr, 0);
        chk("rst_pvld", bus1.psipow4_vld, 0);
        chk("rst_avld", bus1.alpha_r_vld, 0);
        chk("rst_psi", bus1.psi_pow4, 0);
        rst = 1'b0;
        tick(1);

        // 1: four points, gap-free issue, addr-coded data, single done
        rb = rd_cnt; pb = pv_cnt; ab = av_cnt; db = done_cnt;
        n_points = 4; start = 1'b1; t0 = cyc;
        tick(1);
        start = 1'b0; n_points = 9;
        lim = 0;
        while (done_cnt == db && lim < 200) begin tick(1); lim++; end
        chk("t1_done_seen", (done_cnt > db), 1);
        tick(SK_EXP + 3);
        chk("t1_rd_count", rd_cnt - rb, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_rd_cyc%0d", i), rd_cyc[rb+i], t0 + 1 + i);
            chk($sformatf("t1_rd_adr%0d", i), rd_adr[rb+i], i);
            chk($sformatf("t1_pv_cyc%0d", i), pv_cyc[pb+i], t0 + 1 + i + RDL + 1);
            chk($sformatf("t1_psi%0d", i), pv_psi[pb+i], PSI_B | 64'(i));
            chk($sformatf("t1_ri%0d", i), pv_ri[pb+i], RI_B | 64'(i));
            chk($sformatf("t1_av_cyc%0d", i), av_cyc[ab+i], t0 + 1 + i + RDL + 1 + SK_EXP);
            chk($sformatf("t1_alpha%0d", i), av_dat[ab+i], AL_B | 64'(i));
        end
        chk("t1_pv_count", pv_cnt - pb, 4);
        chk("t1_max_inflight", max_inf, 4);
        chk("t1_done_count", done_cnt - db, 1);
        last_ret = t0 + 4 + RDL + 1 + 30;
        chk("t1_done_time", (done_cyc == last_ret + 1 || done_cyc == last_ret + 2), 1);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_inflight", inflight, 0);

        // 4b: stray return in IDLE sets a sticky error
        chk("t4_err_before", err, 0);
        man_ret = 1'b1;
        tick(1);
        man_ret = 1'b0;
        chk("t4_err_set", err, 1);
        chk("t4_inflight_zero", inflight, 0);
        tick(5);
        chk("t4_err_sticky", err, 1);

        // 2: zero-length job
        rb = rd_cnt; db = done_cnt;
        n_points = 0; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t2_done_pulse", done, 1);
        chk("t2_busy_done", busy, 1);
        tick(1);
        chk("t2_done_low", done, 0);
        chk("t2_busy_low", busy, 0);
        tick(2);
        chk("t2_done_count", done_cnt - db, 1);
        chk("t2_no_reads", rd_cnt - rb, 0);

        // 3: credit limit 2, each return frees one more read
        n_points2 = 5; start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        tick(39);
        chk("t3_stall_reads", rd2_cnt, 2);
        chk("t3_stall_inflight", inflight2, 2);
        chk("t3_stall_busy", busy2, 1);
        for (int j = 0; j < 3; j++) begin
            ret2 = 1'b1;
            tick(1);
            ret2 = 1'b0;
            tick(4);
            chk($sformatf("t3_release%0d", j), rd2_cnt, 3 + j);
        end
        ret2 = 1'b1; tick(1); ret2 = 1'b0; tick(4);
        chk("t3_no_early_done", done2_cnt, 0);
        ret2 = 1'b1; tick(1); ret2 = 1'b0; tick(4);
        chk("t3_done", done2_cnt, 1);
        chk("t3_total_reads", rd2_cnt, 5);
        chk("t3_err", err2, 0);

        // 4a: return coincident with issue keeps inflight
        db = done2_cnt;
        n_points2 = 3; start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        tick(1);
        chk("t4_pre_inflight", inflight2, 1);
        chk("t4_pre_issue", bus2.mem_rd_en, 1);
        ret2 = 1'b1;
        tick(1);
        ret2 = 1'b0;
        chk("t4_coincident", inflight2, 1);
        tick(1);
        chk("t4_after_issue", inflight2, 2);
        ret2 = 1'b1; tick(1); ret2 = 1'b0; tick(2);
        ret2 = 1'b1; tick(1); ret2 = 1'b0; tick(4);
        chk("t4_done", done2_cnt - db, 1);
        chk("t4_err2", err2, 0);

        // 5: reset mid-job
        n_points = 8; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        rst = 1'b1;
        pb = pv_cnt; ab = av_cnt;
        tick(1);
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_err", err, 0);
        chk("t5_inflight", inflight, 0);
        chk("t5_rd_en", bus1.mem_rd_en, 0);
        chk("t5_rd_addr", bus1.mem_rd_addr, 0);
        chk("t5_pvld", bus1.psipow4_vld, 0);
        chk("t5_avld", bus1.alpha_r_vld, 0);
        chk("t5_psi", bus1.psi_pow4, 0);
        chk("t5_ri", bus1.r_i, 0);
        chk("t5_alpha", bus1.alpha_r, 0);
        tick(SKEW + 10);
        chk("t5_no_stray_pvld", pv_cnt - pb, 0);
        chk("t5_no_stray_avld", av_cnt - ab, 0);
        rb = rd_cnt; db = done_cnt;
        n_points = 2; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t5_restart_en", bus1.mem_rd_en, 1);
        chk("t5_restart_addr", bus1.mem_rd_addr, 0);
        tick(60);
        chk("t5_restart_reads", rd_cnt - rb, 2);
        chk("t5_restart_done", done_cnt - db, 1);
        chk("t5_restart_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
